// File: rtl/final_video_pkg.sv
// Shared definitions for the final-video palette sequencer: layer encodings,
// default widths and the palette address packing.
package final_video_pkg;

    localparam int PAL_AW_DEF = 10;
    localparam int PAL_DW_DEF = 16;
    localparam int COLBANK_W  = 3;
    localparam int PIX_W      = 7;

    typedef enum logic [1:0] {
        LSEL_SPR  = 2'b00,
        LSEL_L2   = 2'b01,
        LSEL_BG   = 2'b10,
        LSEL_BACK = 2'b11
    } lsel_e;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'b00,
        ARB_PEND = 2'b01,
        ARB_DONE = 2'b10
    } arb_state_e;

    // Palette address layout is {colour bank, pixel code}.
    function automatic logic [COLBANK_W+PIX_W-1:0] pal_pack(
        input logic [COLBANK_W-1:0] cb,
        input logic [PIX_W-1:0]     pix
    );
        return {cb, pix};
    endfunction

endpackage

// File: rtl/final_video_palette_sched_pal_port_arb.sv
// Palette RAM port arbiter: single-entry CPU request buffer, video-priority
// port mux and CPU ack/read-data generation.
module pal_port_arb
    import final_video_pkg::*;
#(
    parameter int PAL_AW = PAL_AW_DEF,
    parameter int PAL_DW = PAL_DW_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vid_issue,
    input  logic [PAL_AW-1:0] vid_addr,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [PAL_AW-1:0] cpu_addr,
    input  logic [PAL_DW-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [PAL_DW-1:0] cpu_rdata,
    output logic [PAL_AW-1:0] pal_addr,
    output logic              pal_we,
    output logic [PAL_DW-1:0] pal_wdata,
    input  logic [PAL_DW-1:0] pal_rdata
);

    arb_state_e        state_q, state_d;
    logic              buf_we_q, buf_we_d;
    logic [PAL_AW-1:0] buf_addr_q, buf_addr_d;
    logic [PAL_DW-1:0] buf_wdata_q, buf_wdata_d;
    logic              ack_q, ack_d;
    logic [PAL_DW-1:0] rdata_q, rdata_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ARB_IDLE;
            buf_we_q    <= 1'b0;
            buf_addr_q  <= '0;
            buf_wdata_q <= '0;
            ack_q       <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            buf_we_q    <= buf_we_d;
            buf_addr_q  <= buf_addr_d;
            buf_wdata_q <= buf_wdata_d;
            ack_q       <= ack_d;
            rdata_q     <= rdata_d;
        end
    end

    // PEND = buffer full and waiting for a free slot; DONE = access issued,
    // RAM data returns this cycle.
    always_comb begin
        state_d     = state_q;
        buf_we_d    = buf_we_q;
        buf_addr_d  = buf_addr_q;
        buf_wdata_d = buf_wdata_q;
        ack_d       = 1'b0;
        rdata_d     = rdata_q;
        case (state_q)
            ARB_IDLE: begin
                // Blocking on ack_q stops the still-held request being recaptured.
                if (cpu_req && !ack_q) begin
                    buf_we_d    = cpu_we;
                    buf_addr_d  = cpu_addr;
                    buf_wdata_d = cpu_wdata;
                    state_d     = ARB_PEND;
                end
            end
            ARB_PEND: begin
                if (!vid_issue) begin
                    state_d = ARB_DONE;
                end
            end
            ARB_DONE: begin
                ack_d = 1'b1;
                if (!buf_we_q) begin
                    rdata_d = pal_rdata;
                end
                state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        pal_addr  = '0;
        pal_we    = 1'b0;
        pal_wdata = '0;
        if (vid_issue) begin
            pal_addr = vid_addr;
        end else if (state_q == ARB_PEND) begin
            pal_addr  = buf_addr_q;
            pal_we    = buf_we_q;
            pal_wdata = buf_we_q ? buf_wdata_q : '0;
        end
    end

    assign cpu_ack   = ack_q;
    assign cpu_rdata = rdata_q;

endmodule

// File: rtl/final_video_palette_sched.sv
// Per-pixel palette lookup sequencer: latches the mixer decision on pixel_ce,
// issues the video palette read and registers the resulting colour.
module final_video_palette_sched
    import final_video_pkg::*;
#(
    parameter int PAL_AW = PAL_AW_DEF,
    parameter int PAL_DW = PAL_DW_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pixel_ce,
    input  logic                 blank,
    input  logic [1:0]           layer_sel,
    input  logic [COLBANK_W-1:0] colbank,
    input  logic [PIX_W-1:0]     spr_pix,
    input  logic [PIX_W-1:0]     l2_pix,
    input  logic [PIX_W-1:0]     bg_pix,
    input  logic                 cpu_req,
    input  logic                 cpu_we,
    input  logic [PAL_AW-1:0]    cpu_addr,
    input  logic [PAL_DW-1:0]    cpu_wdata,
    output logic                 cpu_ack,
    output logic [PAL_DW-1:0]    cpu_rdata,
    output logic [PAL_AW-1:0]    pal_addr,
    output logic                 pal_we,
    output logic [PAL_DW-1:0]    pal_wdata,
    input  logic [PAL_DW-1:0]    pal_rdata,
    output logic [PAL_DW-1:0]    rgb_out,
    output logic                 rgb_valid
);

    logic [1:0]           lsel_q, lsel_d;
    logic [COLBANK_W-1:0] colbank_q, colbank_d;
    logic                 blank_q, blank_d;
    logic [PIX_W-1:0]     spr_q, spr_d;
    logic [PIX_W-1:0]     l2_q, l2_d;
    logic [PIX_W-1:0]     bg_q, bg_d;
    logic                 s0_valid_q, s0_valid_d;
    logic                 lat_valid_q, lat_valid_d;
    logic                 vid_lat_q, vid_lat_d;
    logic [PAL_DW-1:0]    rgb_q, rgb_d;
    logic                 rgb_valid_q, rgb_valid_d;

    logic                 vid_issue;
    logic [PIX_W-1:0]     pix_sel;
    logic [PAL_AW-1:0]    vid_addr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lsel_q      <= '0;
            colbank_q   <= '0;
            blank_q     <= 1'b0;
            spr_q       <= '0;
            l2_q        <= '0;
            bg_q        <= '0;
            s0_valid_q  <= 1'b0;
            lat_valid_q <= 1'b0;
            vid_lat_q   <= 1'b0;
            rgb_q       <= '0;
            rgb_valid_q <= 1'b0;
        end else begin
            lsel_q      <= lsel_d;
            colbank_q   <= colbank_d;
            blank_q     <= blank_d;
            spr_q       <= spr_d;
            l2_q        <= l2_d;
            bg_q        <= bg_d;
            s0_valid_q  <= s0_valid_d;
            lat_valid_q <= lat_valid_d;
            vid_lat_q   <= vid_lat_d;
            rgb_q       <= rgb_d;
            rgb_valid_q <= rgb_valid_d;
        end
    end

    always_comb begin
        unique case (lsel_e'(lsel_q))
            LSEL_SPR:  pix_sel = spr_q;
            LSEL_L2:   pix_sel = l2_q;
            LSEL_BG:   pix_sel = bg_q;
            LSEL_BACK: pix_sel = '0;
            default:   pix_sel = '0;
        endcase
    end

    assign vid_issue = s0_valid_q && !blank_q;
    assign vid_addr  = PAL_AW'(pal_pack(colbank_q, pix_sel));

    always_comb begin
        lsel_d      = lsel_q;
        colbank_d   = colbank_q;
        blank_d     = blank_q;
        spr_d       = spr_q;
        l2_d        = l2_q;
        bg_d        = bg_q;
        rgb_d       = rgb_q;
        s0_valid_d  = pixel_ce;
        lat_valid_d = s0_valid_q;
        vid_lat_d   = vid_issue;
        rgb_valid_d = lat_valid_q;
        if (pixel_ce) begin
            lsel_d    = layer_sel;
            colbank_d = colbank;
            blank_d   = blank;
            spr_d     = spr_pix;
            l2_d      = l2_pix;
            bg_d      = bg_pix;
        end
        // Blanked pixels still produce a strobe, with black instead of RAM data.
        if (lat_valid_q) begin
            rgb_d = vid_lat_q ? pal_rdata : '0;
        end
    end

    pal_port_arb #(
        .PAL_AW(PAL_AW),
        .PAL_DW(PAL_DW)
    ) u_arb (
        .clk       (clk),
        .reset     (reset),
        .vid_issue (vid_issue),
        .vid_addr  (vid_addr),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ack   (cpu_ack),
        .cpu_rdata (cpu_rdata),
        .pal_addr  (pal_addr),
        .pal_we    (pal_we),
        .pal_wdata (pal_wdata),
        .pal_rdata (pal_rdata)
    );

    assign rgb_out   = rgb_q;
    assign rgb_valid = rgb_valid_q;

endmodule

// File: tb/tb_final_video_palette_sched.sv
// Directed bench for final_video_palette_sched with a synchronous palette RAM model.
module tb_final_video_palette_sched;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pixel_ce = 1'b0;
    logic        blank = 1'b0;
    logic [1:0]  layer_sel = 2'b00;
    logic [2:0]  colbank = 3'd0;
    logic [6:0]  spr_pix = 7'h11;
    logic [6:0]  l2_pix = 7'h2A;
    logic [6:0]  bg_pix = 7'h33;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [9:0]  cpu_addr = 10'h0;
    logic [15:0] cpu_wdata = 16'h0;
    logic        cpu_ack;
    logic [15:0] cpu_rdata;
    logic [9:0]  pal_addr;
    logic        pal_we;
    logic [15:0] pal_wdata;
    logic [15:0] pal_rdata;
    logic [15:0] rgb_out;
    logic        rgb_valid;

    logic [15:0] mem [0:1023];
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pal_we) mem[pal_addr] <= pal_wdata;
        pal_rdata <= mem[pal_addr];
    end

    final_video_palette_sched dut (
        .clk       (clk),
        .reset     (reset),
        .pixel_ce  (pixel_ce),
        .blank     (blank),
        .layer_sel (layer_sel),
        .colbank   (colbank),
        .spr_pix   (spr_pix),
        .l2_pix    (l2_pix),
        .bg_pix    (bg_pix),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ack   (cpu_ack),
        .cpu_rdata (cpu_rdata),
        .pal_addr  (pal_addr),
        .pal_we    (pal_we),
        .pal_wdata (pal_wdata),
        .pal_rdata (pal_rdata),
        .rgb_out   (rgb_out),
        .rgb_valid (rgb_valid)
    );

    function automatic logic [15:0] pat(input logic [9:0] a);
        return {6'h2D, a};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pixel(input logic [1:0] ls, input logic [2:0] cb, input logic bl,
                         input logic [9:0] exp_addr, input logic [15:0] exp_rgb);
        layer_sel = ls;
        colbank   = cb;
        blank     = bl;
        pixel_ce  = 1'b1;
        tick();
        pixel_ce = 1'b0;
        blank    = 1'b0;
        if (!bl) check("vid_addr", pal_addr, exp_addr);
        else     check("blank_no_issue", pal_addr, 10'h000);
        check("vid_we", pal_we, 1'b0);
        tick();
        check("rgb_valid_early", rgb_valid, 1'b0);
        tick();
        check("rgb_valid", rgb_valid, 1'b1);
        check("rgb_out", rgb_out, exp_rgb);
        $display("[TB] pixel lsel=%0d cb=%0d blank=%0d rgb=%04h", ls, cb, bl, rgb_out);
        tick();
        check("rgb_valid_pulse", rgb_valid, 1'b0);
    endtask

    task automatic cpu_access(input logic we, input logic [9:0] a, input logic [15:0] wd,
                              input logic [15:0] exp_rd);
        bit got;
        got       = 1'b0;
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = a;
        cpu_wdata = wd;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            if (cpu_ack) got = 1'b1;
        end
        cpu_req = 1'b0;
        check("cpu_ack_timeout", got, 1'b1);
        check("cpu_rdata", cpu_rdata, exp_rd);
        $display("[TB] cpu we=%0d addr=%03h rdata=%04h", we, a, cpu_rdata);
    endtask

    initial begin
        logic [15:0] exp_q[$];
        int n_ack;
        int n_valid;
        bit req_done;
        bit saw_ack;
        logic [9:0] cur_addr;

        for (int a = 0; a < 1024; a++) mem[a] = pat(10'(a));
        mem[10'h2AA] = 16'h0F0F;
        mem[10'h100] = 16'h00AA;
        mem[10'h010] = 16'hBEEF;

        // Reset held with a CPU request pending
        cpu_req  = 1'b1;
        cpu_addr = 10'h010;
        repeat (3) tick();
        check("rst_rgb_out", rgb_out, 16'h0);
        check("rst_cpu_ack", cpu_ack, 1'b0);
        check("rst_rgb_valid", rgb_valid, 1'b0);
        check("rst_pal_we", pal_we, 1'b0);
        check("rst_cpu_rdata", cpu_rdata, 16'h0);
        reset = 1'b0;
        tick();
        check("post_rst_issue_addr", pal_addr, 10'h010);
        check("post_rst_ack0", cpu_ack, 1'b0);
        tick();
        check("post_rst_ack1", cpu_ack, 1'b0);
        tick();
        check("post_rst_ack", cpu_ack, 1'b1);
        check("post_rst_rdata", cpu_rdata, 16'hBEEF);
        $display("[TB] cpu post-reset read rdata=%04h", cpu_rdata);
        cpu_req = 1'b0;
        tick();
        check("post_rst_ack_pulse", cpu_ack, 1'b0);

        // Layer selection, backdrop and blanking
        pixel(2'b01, 3'd5, 1'b0, 10'h2AA, 16'h0F0F);
        pixel(2'b11, 3'd2, 1'b0, 10'h100, 16'h00AA);
        pixel(2'b00, 3'd7, 1'b0, 10'h391, pat(10'h391));
        pixel(2'b10, 3'd0, 1'b0, 10'h033, pat(10'h033));
        pixel(2'b01, 3'd5, 1'b1, 10'h000, 16'h0000);

        // Collision: CPU write captured on the same edge as pixel_ce
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 10'h055;
        cpu_wdata = 16'h1234;
        layer_sel = 2'b01;
        colbank   = 3'd5;
        pixel_ce  = 1'b1;
        tick();
        pixel_ce = 1'b0;
        check("coll_vid_addr", pal_addr, 10'h2AA);
        check("coll_vid_we", pal_we, 1'b0);
        check("coll_vid_wdata", pal_wdata, 16'h0);
        tick();
        check("coll_cpu_addr", pal_addr, 10'h055);
        check("coll_cpu_we", pal_we, 1'b1);
        check("coll_cpu_wdata", pal_wdata, 16'h1234);
        tick();
        check("coll_ack_early", cpu_ack, 1'b0);
        check("coll_rgb_valid", rgb_valid, 1'b1);
        check("coll_rgb_out", rgb_out, 16'h0F0F);
        tick();
        check("coll_ack", cpu_ack, 1'b1);
        check("coll_rdata_kept", cpu_rdata, 16'hBEEF);
        $display("[TB] cpu collision write ack");
        cpu_req = 1'b0;
        cpu_access(1'b0, 10'h055, 16'h0, 16'h1234);

        // Throughput: pixel every 4 clk with back-to-back CPU reads
        n_ack    = 0;
        n_valid  = 0;
        req_done = 1'b0;
        cur_addr = 10'h0C0;
        cpu_we   = 1'b0;
        cpu_addr = cur_addr;
        cpu_req  = 1'b1;
        layer_sel = 2'b00;
        colbank   = 3'd1;
        for (int i = 0; i < 48; i++) begin
            if (i < 32 && (i % 4) == 0) begin
                spr_pix  = 7'(i);
                pixel_ce = 1'b1;
                exp_q.push_back(pat({3'd1, 7'(i)}));
            end else begin
                pixel_ce = 1'b0;
            end
            tick();
            if (cpu_ack) begin
                n_ack++;
                check("thr_cpu_rdata", cpu_rdata, pat(cur_addr));
                $display("[TB] cpu read addr=%03h rdata=%04h", cur_addr, cpu_rdata);
                cur_addr = cur_addr + 10'd1;
                cpu_addr = cur_addr;
                if (i >= 32) begin
                    cpu_req  = 1'b0;
                    req_done = 1'b1;
                end
            end
            if (rgb_valid) begin
                n_valid++;
                check("thr_rgb_queue", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) check("thr_rgb_out", rgb_out, exp_q.pop_front());
            end
        end
        cpu_req = 1'b0;
        check("thr_req_drained", req_done, 1'b1);
        check("thr_ack_count", n_ack >= 6, 1'b1);
        check("thr_valid_count", n_valid, 8);
        tick();
        tick();

        // Reset in the cycle after a CPU write capture
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 10'h200;
        cpu_wdata = 16'hDEAD;
        tick();
        reset = 1'b1;
        #1;
        check("midrst_pal_we", pal_we, 1'b0);
        check("midrst_ack", cpu_ack, 1'b0);
        cpu_req = 1'b0;
        tick();
        check("midrst_pal_we_hold", pal_we, 1'b0);
        tick();
        reset   = 1'b0;
        saw_ack = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (cpu_ack) saw_ack = 1'b1;
        end
        check("midrst_no_ack", saw_ack, 1'b0);
        check("midrst_no_write", mem[10'h200], pat(10'h200));
        $display("[TB] mid-access reset dropped request");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
